booth_mul_scheduler: RTL and testbench
======================================

# booth_mul_scheduler

Round-robin scheduler that shares one `booth_multiplier` instance among `NREQ` requesters. It accepts operand pairs over per-requester valid/ready channels and sequences the multiplier's `start`/`done` protocol. Each signed product is returned on a single response channel tagged with the requester id. It sits between the client logic and the multiplier, which it controls through the `mul_*` ports.

## Interface
- `N`, 64: operand width; must equal the multiplier's `N`.
- `NREQ`, 4: number of requesters, 2..16.
- `TIMEOUT`, N+8: maximum cycles in WAIT before an error response is returned.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: synchronous, active-low reset.
- `req_valid`  in  NREQ: per-requester request valid.
- `req_ready`  out  NREQ: per-requester accept; one-hot or zero.
- `req_a`  in  NREQ×N (packed): signed multiplicands.
- `req_b`  in  NREQ×N (packed): signed multipliers.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: response accept.
- `rsp_id`  out  $clog2(NREQ): id of the requester being answered.
- `rsp_product`  out  2N: signed product.
- `rsp_err`  out  1: timeout flag; `rsp_product` is 0 when set.
- `mul_start`  out  1: one-cycle start pulse to the multiplier.
- `mul_multiplicand`, `mul_multiplier`  out  N: operands, held stable from ISSUE through WAIT.
- `mul_product`  in  2N: multiplier result.
- `mul_done`  in  1: multiplier done level.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- The FSM has four states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - If any `req_valid` is high, the round-robin arbiter picks a grant `g`.
  - `req_ready[g]` is driven combinationally high in the same cycle.
  - On that cycle the block latches `req_a[g]`, `req_b[g]` and `g`, then goes to ISSUE.
  - Round-robin pointer moves to g+1 mod NREQ; the search starts from the pointer.
- **ISSUE**
  - `mul_start`=1 for exactly one cycle, then go to WAIT.
  - `mul_done` is ignored in ISSUE because it may still be high from the previous operation.
- **WAIT**
  - A cycle counter increments each cycle.
  - On `mul_done`=1, capture `mul_product` into the response register with `rsp_err`=0, then go to RESP.
  - If the counter reaches TIMEOUT with no done, capture product 0 with `rsp_err`=1, then go to RESP.
- **RESP**
  - `rsp_valid`=1 with `rsp_id`, `rsp_product` and `rsp_err` held stable until `rsp_ready`=1.
  - On the handshake cycle, go to IDLE.
  - No request is accepted outside IDLE; all `req_ready` are 0.
- Operands and product are passed unmodified; width and sign handling belong to the multiplier.
- The block never pulses `mul_start` while in WAIT.
- Reset leaves the multiplier untouched. A multiplier still running after reset is restarted by the next ISSUE pulse, which also clears its `done`.

## Timing
- Reset values:
  - state IDLE, RR pointer 0, counter 0.
  - `req_ready`, `rsp_valid`, `rsp_err`, `mul_start` and `busy` all 0.
  - `rsp_id`, `rsp_product`, `mul_multiplicand` and `mul_multiplier` all 0.
- Per-operation timeline, with the request accepted in cycle 0:
  - Cycle 0: request handshake.
  - Cycle 1: `mul_start`=1.
  - Cycle N+3: `mul_done` first high; the product is captured at the end of this cycle.
  - Cycle N+4: `rsp_valid` rises.
- Latency from accept to `rsp_valid` is N+4 cycles. Minimum issue interval is N+5 cycles when `rsp_ready` is held high.
- Simultaneous requests: exactly one is granted. Requesters that lose keep `req_valid` asserted and are served in round-robin order.
- Reset asserted in any state takes the block to IDLE on the next edge. Any pending response is dropped.

## Structure
- **Package `booth_sched_pkg`**
  - State enum `sched_state_t` with values IDLE, ISSUE, WAIT, RESP.
  - Function `id_w(NREQ)`.
- **Sub-module `rr_arbiter`** (natural to split out)
  - Parameter `NREQ`.
  - Inputs `req`, `ptr`.
  - Output one-hot `gnt`, plus `gnt_id`.
  - Purely combinational; the pointer register stays in the scheduler.
- The top-level integration (outside this block) instantiates `booth_multiplier` and connects the `mul_*` ports.

## Test plan
Bench uses N=8, NREQ=4 and the real `booth_multiplier` unless a case says otherwise.
1. **Single request:** req0 sends a=7, b=-3 → `rsp_valid` in cycle 12, `rsp_id`=0, `rsp_product`=0xFFEB (-21), `rsp_err`=0.
2. **Simultaneous requests:** req0 and req2 sent together (2×3 and 4×5) → first response id 0 with 6, then id 2 with 20. With the pointer then at 3, req1 and req3 sent together → id 3 first.
3. **Backpressure:** `rsp_ready` held low 5 cycles → `rsp_valid` and `rsp_product` stable throughout, all `req_ready`=0, no `mul_start` pulse. The cycle after the handshake is IDLE.
4. **Extreme operands:** a=-128, b=-128 → 0x4000. a=-128, b=127 → 0xC080. a=0, b=-1 → 0.
5. **Timeout:** `mul_done` forced to 0 → after TIMEOUT=16 cycles in WAIT, `rsp_valid` rises with `rsp_err`=1 and product 0. The next request then completes normally.
6. **Reset mid-WAIT:** `rst_n` asserted low for one cycle mid-WAIT → all outputs return to their reset values and no response is emitted. The next request returns the correct product with the normal N+4 latency.

Source files
------------

// File: rtl/booth_sched_pkg.sv
// rtl/booth_sched_pkg.sv - shared types and helpers for the booth multiplier scheduler
// Purpose: FSM state encoding and id width helper used by the scheduler and its arbiter.
// Ports: none (package).
package booth_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    // Width of a requester id; never below one bit so ports stay legal.
    function automatic int id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Purpose: picks the first asserted request at or after ptr, wrapping around.
// Ports:
//   req    in  NREQ : request vector
//   ptr    in  IW   : index where the search starts
//   gnt    out NREQ : one-hot grant (zero when no request)
//   gnt_id out IW   : index of the granted request (0 when none)
module rr_arbiter
    import booth_sched_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_id
);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // ptr < NREQ and the offset < NREQ, so one conditional subtract wraps the index.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/booth_mul_scheduler.sv
// rtl/booth_mul_scheduler.sv - round-robin sharing of one booth multiplier among NREQ requesters
// Purpose: accepts operand pairs, sequences the multiplier start/done protocol and
//          returns each product tagged with the requester id (or a timeout error).
// Ports:
//   clk, rst_n                        : clock, synchronous active-low reset
//   req_valid/req_ready [NREQ]        : per-requester handshake (ready one-hot or zero)
//   req_a/req_b [NREQ*N]              : packed signed operands per requester
//   rsp_valid/rsp_ready               : response handshake
//   rsp_id, rsp_product, rsp_err      : response payload (product 0 on error)
//   mul_start                         : one-cycle start pulse to the multiplier
//   mul_multiplicand/mul_multiplier   : operands held from ISSUE through WAIT
//   mul_product, mul_done             : multiplier result and done level
//   busy                              : high whenever not IDLE
module booth_mul_scheduler
    import booth_sched_pkg::*;
#(
    parameter int N       = 64,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = N + 8,
    localparam int IW = id_w(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IW-1:0]     rsp_id,
    output logic [2*N-1:0]    rsp_product,
    output logic              rsp_err,
    output logic              mul_start,
    output logic [N-1:0]      mul_multiplicand,
    output logic [N-1:0]      mul_multiplier,
    input  logic [2*N-1:0]    mul_product,
    input  logic              mul_done,
    output logic              busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    sched_state_t  state;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_id;
    logic [IW-1:0]   next_ptr;
    logic [N-1:0]    sel_a;
    logic [N-1:0]    sel_b;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Operand mux keyed by the granted id.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IW'(i)) begin
                sel_a = req_a[i*N +: N];
                sel_b = req_b[i*N +: N];
            end
        end
    end

    assign next_ptr = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

    assign req_ready = (state == IDLE) ? gnt : '0;
    assign mul_start = (state == ISSUE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            ptr              <= '0;
            cnt              <= '0;
            rsp_id           <= '0;
            rsp_product      <= '0;
            rsp_err          <= 1'b0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        mul_multiplicand <= sel_a;
                        mul_multiplier   <= sel_b;
                        rsp_id           <= gnt_id;
                        ptr              <= next_ptr;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    // mul_done may still be high from the previous operation; the
                    // start pulse issued this cycle clears it, so WAIT sees a fresh level.
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (mul_done) begin
                        rsp_product <= mul_product;
                        rsp_err     <= 1'b0;
                        state       <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rsp_product <= '0;
                        rsp_err     <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// tb/tb_booth_mul_scheduler.sv - self-checking bench for booth_mul_scheduler
module tb_booth_mul_scheduler;

    localparam int N       = 8;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = N + 8;
    localparam int LAT     = N + 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*N-1:0]   req_a = '0;
    logic [NREQ*N-1:0]   req_b = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [1:0]          rsp_id;
    logic [2*N-1:0]      rsp_product;
    logic                rsp_err;
    logic                mul_start;
    logic [N-1:0]        mul_multiplicand;
    logic [N-1:0]        mul_multiplier;
    logic [2*N-1:0]      mul_product;
    logic                mul_done;
    logic                busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int m_ptr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier: done rises N+2 cycles after the start cycle and
    // stays high until the next start; reset does not touch it.
    logic [2*N-1:0] m_prod = '0;
    logic           m_done = 1'b0;
    int             m_cnt  = 0;
    bit             m_busy = 1'b0;
    bit             hold_done_low = 1'b0;

    always @(posedge clk) begin
        if (mul_start) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_prod <= $signed(mul_multiplicand) * $signed(mul_multiplier);
        end else if (m_busy) begin
            if (m_cnt == N) begin
                m_busy <= 1'b0;
                m_done <= !hold_done_low;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    assign mul_product = m_prod;
    assign mul_done    = m_done;

    booth_mul_scheduler #(
        .N       (N),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_a            (req_a),
        .req_b            (req_b),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_id           (rsp_id),
        .rsp_product      (rsp_product),
        .rsp_err          (rsp_err),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product      (mul_product),
        .mul_done         (mul_done),
        .busy             (busy)
    );

    function automatic logic [15:0] ref_mul(input logic signed [7:0] a, input logic signed [7:0] b);
        int p;
        p = int'(a) * int'(b);
        return p[15:0];
    endfunction

    task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b);
        req_a[r*N +: N] = a;
        req_b[r*N +: N] = b;
        req_valid[r]    = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    // Waits for one grant and its response; returns observations only.
    task automatic collect(output int gid, output int rid, output logic [15:0] prod,
                           output logic err, output int lat, output bit ok);
        int acc;
        bit got;
        gid = -1; rid = -1; prod = '0; err = 1'b0; lat = -1; ok = 1'b0; acc = 0; got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            #1;
            if (req_ready != '0) begin
                got = 1'b1;
                acc = cyc;
                for (int k = 0; k < NREQ; k++) if (req_ready[k]) gid = k;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) return;
        @(negedge clk);
        req_valid[gid] = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            if (rsp_valid) begin
                ok   = 1'b1;
                rid  = int'(rsp_id);
                prod = rsp_product;
                err  = rsp_err;
                lat  = cyc - acc;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if ({req_ready, rsp_valid, rsp_err, mul_start, busy} !== 8'h00) begin
            bad++; $display("FAIL reset_ctrl: got %b want 00000000", {req_ready, rsp_valid, rsp_err, mul_start, busy});
        end
        total++; if ({rsp_id, rsp_product, mul_multiplicand, mul_multiplier} !== 34'h0) begin
            bad++; $display("FAIL reset_data: got id=%0d prod=%h a=%h b=%h want all 0", rsp_id, rsp_product, mul_multiplicand, mul_multiplier);
        end
    endtask

    task automatic test_single();
        int gid, rid, lat; logic [15:0] prod; logic err; bit ok;
        @(negedge clk);
        set_req(0, 8'd7, 8'hFD);
        collect(gid, rid, prod, err, lat, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_ok: got no response want response"); end
        total++; if (lat !== LAT) begin bad++; $display("FAIL single_lat: got %0d want %0d", lat, LAT); end
        total++; if (rid !== 0) begin bad++; $display("FAIL single_id: got %0d want 0", rid); end
        total++; if (prod !== 16'hFFEB) begin bad++; $display("FAIL single_prod: got %h want ffeb", prod); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", err); end
        total++; if (mul_multiplicand !== 8'd7 || mul_multiplier !== 8'hFD) begin
            bad++; $display("FAIL single_ops: got %h/%h want 07/fd", mul_multiplicand, mul_multiplier);
        end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int gid, rid, lat; logic [15:0] prod; logic err; bit ok;
        int exp_id[4];
        logic [15:0] exp_p[4];
        exp_id = '{0, 2, 3, 1};
        exp_p  = '{16'd6, 16'd20, 16'hFFF4, 16'd9};
        do_reset();
        set_req(0, 8'd2, 8'd3);
        set_req(2, 8'd4, 8'd5);
        for (int s = 0; s < 4; s++) begin
            if (s == 2) begin
                set_req(1, 8'd3, 8'd3);
                set_req(3, 8'hFE, 8'd6);
            end
            collect(gid, rid, prod, err, lat, ok);
            total++; if (rid !== exp_id[s]) begin bad++; $display("FAIL simul_id%0d: got %0d want %0d", s, rid, exp_id[s]); end
            total++; if (prod !== exp_p[s]) begin bad++; $display("FAIL simul_prod%0d: got %h want %h", s, prod, exp_p[s]); end
            @(negedge clk);
        end
        m_ptr = 2;
    endtask

    task automatic test_backpressure();
        int gid, rid, lat; logic [15:0] prod; logic err; bit ok;
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(2, 8'd10, 8'd11);
        collect(gid, rid, prod, err, lat, ok);
        total++; if (prod !== 16'd110 || rid !== 2) begin bad++; $display("FAIL bp_first: got id=%0d prod=%h want id=2 prod=006e", rid, prod); end
        set_req(0, 8'hFB, 8'd6);
        for (int i = 0; i < 5; i++) begin
            total++; if (rsp_valid !== 1'b1 || rsp_product !== 16'd110 || rsp_id !== 2'd2) begin
                bad++; $display("FAIL bp_hold%0d: got v=%b prod=%h id=%0d want v=1 prod=006e id=2", i, rsp_valid, rsp_product, rsp_id);
            end
            total++; if (req_ready !== 4'b0000 || mul_start !== 1'b0) begin
                bad++; $display("FAIL bp_quiet%0d: got ready=%b start=%b want 0000/0", i, req_ready, mul_start);
            end
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
            bad++; $display("FAIL bp_idle: got busy=%b v=%b ready=%b want 0/0/0001", busy, rsp_valid, req_ready);
        end
        collect(gid, rid, prod, err, lat, ok);
        total++; if (rid !== 0 || prod !== 16'hFFE2) begin bad++; $display("FAIL bp_next: got id=%0d prod=%h want id=0 prod=ffe2", rid, prod); end
        @(negedge clk);
    endtask

    task automatic test_extreme();
        int gid, rid, lat; logic [15:0] prod; logic err; bit ok;
        logic [7:0] xa[3];
        logic [7:0] xb[3];
        logic [15:0] xp[3];
        xa = '{8'h80, 8'h80, 8'h00};
        xb = '{8'h80, 8'h7F, 8'hFF};
        xp = '{16'h4000, 16'hC080, 16'h0000};
        for (int s = 0; s < 3; s++) begin
            set_req(1, xa[s], xb[s]);
            collect(gid, rid, prod, err, lat, ok);
            total++; if (prod !== xp[s] || err !== 1'b0) begin
                bad++; $display("FAIL extreme%0d: got prod=%h err=%b want %h/0", s, prod, err, xp[s]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        int gid, rid, lat; logic [15:0] prod; logic err; bit ok;
        hold_done_low = 1'b1;
        set_req(3, 8'd5, 8'd5);
        collect(gid, rid, prod, err, lat, ok);
        total++; if (lat !== TIMEOUT + 2) begin bad++; $display("FAIL timeout_lat: got %0d want %0d", lat, TIMEOUT + 2); end
        total++; if (err !== 1'b1 || prod !== 16'h0) begin bad++; $display("FAIL timeout_rsp: got err=%b prod=%h want 1/0000", err, prod); end
        @(negedge clk);
        hold_done_low = 1'b0;
        set_req(3, 8'hFA, 8'd7);
        collect(gid, rid, prod, err, lat, ok);
        total++; if (lat !== LAT || err !== 1'b0 || prod !== 16'hFFD6) begin
            bad++; $display("FAIL timeout_next: got lat=%0d err=%b prod=%h want %0d/0/ffd6", lat, err, prod, LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        int gid, rid, lat; logic [15:0] prod; logic err; bit ok; bit got; bit seen;
        got = 1'b0; seen = 1'b0;
        set_req(1, 8'd9, 8'd9);
        for (int i = 0; i < 50 && !got; i++) begin
            #1;
            if (req_ready[1]) got = 1'b1;
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        total++; if (!got) begin bad++; $display("FAIL rstw_accept: got no grant want grant"); end
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if ({req_ready, rsp_valid, rsp_err, mul_start, busy} !== 8'h00) begin
            bad++; $display("FAIL rstw_ctrl: got %b want 00000000", {req_ready, rsp_valid, rsp_err, mul_start, busy});
        end
        total++; if ({rsp_id, rsp_product, mul_multiplicand, mul_multiplier} !== 34'h0) begin
            bad++; $display("FAIL rstw_data: got id=%0d prod=%h a=%h b=%h want all 0", rsp_id, rsp_product, mul_multiplicand, mul_multiplier);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstw_norsp: got response want none"); end
        m_ptr = 0;
        @(negedge clk);
        set_req(2, 8'hF7, 8'd9);
        collect(gid, rid, prod, err, lat, ok);
        total++; if (lat !== LAT || rid !== 2 || prod !== 16'hFFAF || err !== 1'b0) begin
            bad++; $display("FAIL rstw_next: got lat=%0d id=%0d prod=%h err=%b want %0d/2/ffaf/0", lat, rid, prod, err, LAT);
        end
        @(negedge clk);
        m_ptr = 3;
    endtask

    task automatic test_random();
        int gid, rid, lat; logic [15:0] prod; logic err; bit ok;
        logic [3:0] pending;
        logic [7:0] ea[4];
        logic [7:0] eb[4];
        int want;
        do_reset();
        for (int batch = 0; batch < 12; batch++) begin
            pending = 4'($urandom_range(1, 15));
            for (int r = 0; r < NREQ; r++) begin
                ea[r] = 8'($urandom);
                eb[r] = 8'($urandom);
                if (pending[r]) set_req(r, ea[r], eb[r]);
            end
            while (pending != 0) begin
                want = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (want < 0 && pending[(m_ptr + k) % NREQ]) want = (m_ptr + k) % NREQ;
                end
                collect(gid, rid, prod, err, lat, ok);
                total++; if (rid !== want || gid !== want) begin
                    bad++; $display("FAIL rand_id b%0d: got grant=%0d rsp=%0d want %0d", batch, gid, rid, want);
                end
                total++; if (prod !== ref_mul(ea[want], eb[want]) || err !== 1'b0 || lat !== LAT) begin
                    bad++; $display("FAIL rand_rsp b%0d: got prod=%h err=%b lat=%0d want %h/0/%0d", batch, prod, err, lat, ref_mul(ea[want], eb[want]), LAT);
                end
                pending[want] = 1'b0;
                if (gid >= 0) req_valid[gid] = 1'b0;
                m_ptr = (want + 1) % NREQ;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_extreme();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
